// File: rtl/llc_stall_tracker_pkg.sv
// rtl/llc_stall_tracker_pkg.sv - shared cache types for the LLC stall tracker
//
// Purpose: field widths, the default tracker depth and the per-slot entry
// struct. LLC_SET_BITS / LLC_TAG_BITS fall back to local defaults when the
// cache build does not define them.
`ifndef LLC_SET_BITS
`define LLC_SET_BITS 6
`endif
`ifndef LLC_TAG_BITS
`define LLC_TAG_BITS 8
`endif

package llc_stall_tracker_pkg;

  localparam int LLC_SET_W           = `LLC_SET_BITS;
  localparam int LLC_TAG_W           = `LLC_TAG_BITS;
  localparam int LLC_STALL_N_ENTRIES = 4;

  typedef struct packed {
    logic                 valid;
    logic                 blocked;
    logic [LLC_SET_W-1:0] set;
    logic [LLC_TAG_W-1:0] tag;
    logic                 is_dma;
  } llc_stall_entry_t;

endpackage

// File: rtl/llc_stall_tracker_if.sv
// rtl/llc_stall_tracker_if.sv - decoder/FSM-facing bus of the LLC stall tracker
//
// Purpose: groups the alloc, lookup, release and resume signals.
// Modports:
//   master - request decoder / LLC FSM side (drives alloc_*, lookup_set,
//            release_*, resume_ready)
//   slave  - the tracker itself
interface llc_stall_tracker_if #(
  parameter int SET_W = llc_stall_tracker_pkg::LLC_SET_W,
  parameter int TAG_W = llc_stall_tracker_pkg::LLC_TAG_W
);

  logic             alloc_valid;
  logic             alloc_ready;
  logic [SET_W-1:0] alloc_set;
  logic [TAG_W-1:0] alloc_tag;
  logic             alloc_is_dma;

  logic [SET_W-1:0] lookup_set;
  logic             lookup_hit;

  logic             release_en;
  logic [SET_W-1:0] release_set;

  logic             resume_valid;
  logic             resume_ready;
  logic [SET_W-1:0] resume_set;
  logic [TAG_W-1:0] resume_tag;
  logic             resume_is_dma;

  modport master (
    output alloc_valid, alloc_set, alloc_tag, alloc_is_dma,
    output lookup_set, release_en, release_set, resume_ready,
    input  alloc_ready, lookup_hit,
    input  resume_valid, resume_set, resume_tag, resume_is_dma
  );

  modport slave (
    input  alloc_valid, alloc_set, alloc_tag, alloc_is_dma,
    input  lookup_set, release_en, release_set, resume_ready,
    output alloc_ready, lookup_hit,
    output resume_valid, resume_set, resume_tag, resume_is_dma
  );

endinterface

// File: rtl/llc_stall_tracker_stats.sv
// rtl/llc_stall_tracker_stats.sv - allocation counter and occupancy high-water mark
//
// Purpose: module llc_stall_stats, used by llc_stall_tracker only when
// LLC_STALL_STATS_EN is defined.
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   rst_state      synchronous clear
//   alloc_fire     an allocation is accepted this cycle
//   count_d        occupancy after this edge
//   stat_allocs    accepted allocations, saturating at 16'hFFFF
//   stat_hiwater   largest occupancy seen since reset
module llc_stall_stats #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rst_state,
  input  logic             alloc_fire,
  input  logic [CNT_W-1:0] count_d,
  output logic [15:0]      stat_allocs,
  output logic [CNT_W-1:0] stat_hiwater
);

  logic [15:0]      allocs_q, allocs_d;
  logic [CNT_W-1:0] hiwater_q, hiwater_d;

  always_comb begin
    allocs_d  = allocs_q;
    hiwater_d = hiwater_q;
    if (alloc_fire && (allocs_q != 16'hFFFF)) allocs_d = allocs_q + 16'd1;
    // Tracking next-state occupancy keeps the mark in step with count.
    if (count_d > hiwater_q) hiwater_d = count_d;
    if (rst_state) begin
      allocs_d  = '0;
      hiwater_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      allocs_q  <= '0;
      hiwater_q <= '0;
    end else begin
      allocs_q  <= allocs_d;
      hiwater_q <= hiwater_d;
    end
  end

  assign stat_allocs  = allocs_q;
  assign stat_hiwater = hiwater_q;

endmodule

// File: rtl/llc_stall_tracker.sv
// rtl/llc_stall_tracker.sv - FIFO tracker of LLC requests stalled on busy sets
//
// Purpose: holds up to N_ENTRIES stalled requests in arrival order, flags set
// collisions for the decoder and hands unblocked requests back oldest-first.
// Optional statistics are built when LLC_STALL_STATS_EN is defined.
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   rst_state      synchronous soft clear (wins over alloc/release/pop)
//   bus            llc_stall_tracker_if.slave: alloc, lookup, release, resume
//   count          occupancy
//   stat_allocs    accepted allocations (0 without statistics)
//   stat_hiwater   peak occupancy (0 without statistics)
module llc_stall_tracker
  import llc_stall_tracker_pkg::*;
#(
  parameter int  N_ENTRIES = LLC_STALL_N_ENTRIES,
  parameter int  SET_W     = LLC_SET_W,
  parameter int  TAG_W     = LLC_TAG_W,
  localparam int PTR_W     = $clog2(N_ENTRIES),
  localparam int CNT_W     = $clog2(N_ENTRIES + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rst_state,
  llc_stall_tracker_if.slave  bus,
  output logic [CNT_W-1:0]    count,
  output logic [15:0]         stat_allocs,
  output logic [CNT_W-1:0]    stat_hiwater
);

  llc_stall_entry_t entries_q [N_ENTRIES];
  llc_stall_entry_t entries_d [N_ENTRIES];
  llc_stall_entry_t head_e;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full;
  logic             resume_valid;
  logic             alloc_fire;
  logic             pop_fire;
  logic             hit;

  assign full         = (count_q == CNT_W'(N_ENTRIES));
  assign head_e       = entries_q[head_q];
  assign resume_valid = head_e.valid && !head_e.blocked;
  assign alloc_fire   = bus.alloc_valid && !full;
  assign pop_fire     = resume_valid && bus.resume_ready;

  // Collision check sees registered state only, never this cycle's alloc/pop.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (entries_q[i].valid && (entries_q[i].set == LLC_SET_W'(bus.lookup_set))) hit = 1'b1;
    end
  end

  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    // Release matches against entries_q, so the slot written below by a
    // same-cycle alloc keeps blocked=1.
    if (bus.release_en) begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        if (entries_q[i].valid && (entries_q[i].set == LLC_SET_W'(bus.release_set))) begin
          entries_d[i].blocked = 1'b0;
        end
      end
    end
    if (pop_fire) begin
      entries_d[head_q].valid = 1'b0;
      head_d = head_q + PTR_W'(1);
    end
    // head==tail with both firing is impossible: pop needs count>0, alloc needs count<N.
    if (alloc_fire) begin
      entries_d[tail_q] = '{valid:   1'b1,
                            blocked: 1'b1,
                            set:     LLC_SET_W'(bus.alloc_set),
                            tag:     LLC_TAG_W'(bus.alloc_tag),
                            is_dma:  bus.alloc_is_dma};
      tail_d = tail_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(alloc_fire) - CNT_W'(pop_fire);
    if (rst_state) begin
      for (int i = 0; i < N_ENTRIES; i++) entries_d[i] = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_ENTRIES; i++) entries_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

  assign bus.alloc_ready   = !full;
  assign bus.lookup_hit    = hit;
  assign bus.resume_valid  = resume_valid;
  // Head fields read 0 whenever the head slot is empty (reset, drained).
  assign bus.resume_set    = head_e.valid ? SET_W'(head_e.set) : '0;
  assign bus.resume_tag    = head_e.valid ? TAG_W'(head_e.tag) : '0;
  assign bus.resume_is_dma = head_e.valid && head_e.is_dma;
  assign count             = count_q;

`ifdef LLC_STALL_STATS_EN
  llc_stall_stats #(.CNT_W(CNT_W)) u_stats (
    .clk          (clk),
    .rst          (rst),
    .rst_state    (rst_state),
    .alloc_fire   (alloc_fire),
    .count_d      (count_d),
    .stat_allocs  (stat_allocs),
    .stat_hiwater (stat_hiwater)
  );
`else
  assign stat_allocs  = '0;
  assign stat_hiwater = '0;
`endif

endmodule

// File: tb/tb_llc_stall_tracker.sv
// tb/tb_llc_stall_tracker.sv - self-checking bench for llc_stall_tracker
module tb_llc_stall_tracker;
  import llc_stall_tracker_pkg::*;

  localparam int N = 4;

  logic        clk;
  logic        rst;
  logic        rst_state;
  logic [2:0]  count;
  logic [15:0] stat_allocs;
  logic [2:0]  stat_hiwater;

  llc_stall_tracker_if #(.SET_W(LLC_SET_W), .TAG_W(LLC_TAG_W)) bus_if ();

  llc_stall_tracker #(.N_ENTRIES(N), .SET_W(LLC_SET_W), .TAG_W(LLC_TAG_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .rst_state    (rst_state),
    .bus          (bus_if),
    .count        (count),
    .stat_allocs  (stat_allocs),
    .stat_hiwater (stat_hiwater)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: a plain arrival-ordered queue of requests.
  typedef struct {
    logic [LLC_SET_W-1:0] set;
    logic [LLC_TAG_W-1:0] tag;
    logic                 is_dma;
    logic                 blocked;
  } ment_t;

  ment_t       mq[$];
  int unsigned m_allocs  = 0;
  int          m_hiwater = 0;

  task automatic model_clear();
    mq.delete();
    m_allocs  = 0;
    m_hiwater = 0;
  endtask

  // Called just after each rising edge while inputs still hold their values.
  task automatic model_update();
    bit    do_pop;
    bit    do_acc;
    ment_t e;
    if (!rst || rst_state) begin
      model_clear();
    end else begin
      do_pop = (mq.size() > 0) && !mq[0].blocked && bus_if.resume_ready;
      do_acc = bus_if.alloc_valid && (mq.size() < N);
      if (bus_if.release_en)
        foreach (mq[i]) if (mq[i].set == bus_if.release_set) mq[i].blocked = 1'b0;
      if (do_pop) void'(mq.pop_front());
      if (do_acc) begin
        e.set = bus_if.alloc_set; e.tag = bus_if.alloc_tag;
        e.is_dma = bus_if.alloc_is_dma; e.blocked = 1'b1;
        mq.push_back(e);
        m_allocs++;
      end
      if (mq.size() > m_hiwater) m_hiwater = mq.size();
    end
  endtask

  function automatic bit m_hit(input logic [LLC_SET_W-1:0] s);
    foreach (mq[i]) if (mq[i].set == s) return 1'b1;
    return 1'b0;
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    bit          exp_rv;
    logic [15:0] exp_allocs;
    int          exp_hw;
    if (rst) begin
      exp_rv = (mq.size() > 0) && !mq[0].blocked;
`ifdef LLC_STALL_STATS_EN
      exp_allocs = (m_allocs > 65535) ? 16'hFFFF : m_allocs[15:0];
      exp_hw     = m_hiwater;
`else
      exp_allocs = 16'h0;
      exp_hw     = 0;
`endif
      chk("cyc_count", count, mq.size());
      chk("cyc_alloc_ready", bus_if.alloc_ready, mq.size() < N);
      chk("cyc_lookup_hit", bus_if.lookup_hit, m_hit(bus_if.lookup_set));
      chk("cyc_resume_valid", bus_if.resume_valid, exp_rv);
      if (exp_rv) begin
        chk("cyc_resume_set", bus_if.resume_set, mq[0].set);
        chk("cyc_resume_tag", bus_if.resume_tag, mq[0].tag);
        chk("cyc_resume_is_dma", bus_if.resume_is_dma, mq[0].is_dma);
      end
      chk("cyc_stat_allocs", stat_allocs, exp_allocs);
      chk("cyc_stat_hiwater", stat_hiwater, exp_hw);
    end
  end

  task automatic idle();
    bus_if.alloc_valid  = 1'b0;
    bus_if.alloc_set    = '0;
    bus_if.alloc_tag    = '0;
    bus_if.alloc_is_dma = 1'b0;
    bus_if.lookup_set   = '0;
    bus_if.release_en   = 1'b0;
    bus_if.release_set  = '0;
    bus_if.resume_ready = 1'b0;
    rst_state           = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic alloc(input int s, input int t, input bit d);
    bus_if.alloc_valid  = 1'b1;
    bus_if.alloc_set    = LLC_SET_W'(s);
    bus_if.alloc_tag    = LLC_TAG_W'(t);
    bus_if.alloc_is_dma = d;
  endtask

  task automatic rel(input int s);
    bus_if.release_en  = 1'b1;
    bus_if.release_set = LLC_SET_W'(s);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_alloc_ready", bus_if.alloc_ready, 1);
    chk("rst_resume_valid", bus_if.resume_valid, 0);
    chk("rst_lookup_hit", bus_if.lookup_hit, 0);
    chk("rst_stat_allocs", stat_allocs, 0);
    chk("rst_stat_hiwater", stat_hiwater, 0);
    rst = 1'b1;

    // Single entry: blocked until its set is released.
    alloc(5, 3, 1'b1); cyc(); idle();
    bus_if.lookup_set = 5; #1;
    chk("t1_count", count, 1);
    chk("t1_lookup_hit", bus_if.lookup_hit, 1);
    chk("t1_resume_valid", bus_if.resume_valid, 0);
    rel(5); cyc(); idle(); #1;
    chk("t1_rel_resume_valid", bus_if.resume_valid, 1);
    chk("t1_rel_resume_tag", bus_if.resume_tag, 3);
    chk("t1_rel_resume_is_dma", bus_if.resume_is_dma, 1);
    bus_if.resume_ready = 1'b1; cyc(); idle();
    chk("t1_pop_count", count, 0);

    // Fill to N, overflow alloc ignored, younger release does not bypass head.
    for (int i = 1; i <= 4; i++) begin
      alloc(i, 16 + i, 1'b0); cyc();
    end
    idle(); #1;
    chk("t2_alloc_ready", bus_if.alloc_ready, 0);
    chk("t2_count", count, 4);
    alloc(9, 99, 1'b0); cyc(); idle();
    bus_if.lookup_set = 9; #1;
    chk("t2_overflow_count", count, 4);
    chk("t2_overflow_hit", bus_if.lookup_hit, 0);
    rel(2); cyc(); idle(); #1;
    chk("t2_head_blocked", bus_if.resume_valid, 0);

    // Full with unblocked head: pop wins, alloc refused.
    rel(1); cyc(); idle(); #1;
    chk("t3_resume_valid", bus_if.resume_valid, 1);
    chk("t3_resume_tag", bus_if.resume_tag, 17);
    alloc(11, 55, 1'b0); bus_if.resume_ready = 1'b1; cyc(); idle();
    bus_if.lookup_set = 11; #1;
    chk("t3_count", count, 3);
    chk("t3_no_alloc_hit", bus_if.lookup_hit, 0);
    chk("t3_next_tag", bus_if.resume_tag, 18);
    rel(3); bus_if.resume_ready = 1'b1; cyc(); idle();
    rel(4); bus_if.resume_ready = 1'b1; cyc(); idle();
    bus_if.resume_ready = 1'b1; cyc(); idle(); #1;
    chk("t3_drained", count, 0);

    // Same-cycle alloc and release of set 7.
    alloc(7, 1, 1'b0); cyc();
    alloc(7, 2, 1'b1); rel(7); cyc(); idle(); #1;
    chk("t4_count", count, 2);
    chk("t4_old_unblocked", bus_if.resume_valid, 1);
    chk("t4_old_tag", bus_if.resume_tag, 1);
    bus_if.resume_ready = 1'b1; cyc(); idle(); #1;
    chk("t4_new_blocked", bus_if.resume_valid, 0);
    chk("t4_count_after_pop", count, 1);
    rel(7); cyc(); idle();
    bus_if.resume_ready = 1'b1; cyc(); idle();

    // Eight alloc/pop pairs across pointer wrap.
    alloc(32, 8'h40, 1'b0); cyc(); idle();
    rel(32); cyc(); idle();
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("t5_wrap_tag", bus_if.resume_tag, 8'h40 + i);
      alloc(33 + i, 8'h41 + i, i[0]); bus_if.resume_ready = 1'b1; cyc(); idle();
      rel(33 + i); cyc(); idle();
    end
    bus_if.resume_ready = 1'b1; cyc(); idle(); #1;
    chk("t5_drained", count, 0);

`ifdef LLC_STALL_STATS_EN
    chk("t5_stat_allocs", stat_allocs, 16);
    chk("t5_stat_hiwater", stat_hiwater, 4);
`endif

    // Soft clear with three entries; it also beats a same-cycle alloc.
    for (int i = 1; i <= 3; i++) begin
      alloc(i, i, 1'b0); cyc();
    end
    idle(); bus_if.lookup_set = 1; #1;
    chk("t6_hit_before", bus_if.lookup_hit, 1);
    rst_state = 1'b1; alloc(4, 4, 1'b0); cyc(); idle();
    bus_if.lookup_set = 1; #1;
    chk("t6_count", count, 0);
    chk("t6_lookup_hit", bus_if.lookup_hit, 0);
    chk("t6_alloc_ready", bus_if.alloc_ready, 1);

    // Asynchronous reset in the middle of a burst.
    alloc(10, 7, 1'b1); cyc();
    alloc(11, 8, 1'b0); rel(10); cyc();
    alloc(12, 9, 1'b0); bus_if.lookup_set = 10;
    #2;
    rst = 1'b0;
    model_clear();
    #1;
    chk("t7_count", count, 0);
    chk("t7_alloc_ready", bus_if.alloc_ready, 1);
    chk("t7_resume_valid", bus_if.resume_valid, 0);
    chk("t7_lookup_hit", bus_if.lookup_hit, 0);
    chk("t7_resume_set", bus_if.resume_set, 0);
    chk("t7_resume_tag", bus_if.resume_tag, 0);
    chk("t7_resume_is_dma", bus_if.resume_is_dma, 0);
    chk("t7_stat_allocs", stat_allocs, 0);
    chk("t7_stat_hiwater", stat_hiwater, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    idle();
    cyc();

`ifdef LLC_STALL_STATS_EN
    // Saturation: one alloc per cycle with steady occupancy of two.
    alloc(1, 1, 1'b0); cyc(); idle();
    rel(1); cyc();
    for (int i = 0; i < 65540; i++) begin
      alloc(1, i[7:0], 1'b0); rel(1); bus_if.resume_ready = 1'b1; cyc();
    end
    idle(); #1;
    chk("t8_stat_allocs", stat_allocs, 16'hFFFF);
    chk("t8_stat_hiwater", stat_hiwater, 2);
`else
    chk("t8_stat_allocs_off", stat_allocs, 0);
    chk("t8_stat_hiwater_off", stat_hiwater, 0);
`endif

    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
